// File: rtl/player_bullet_pkg.sv
// player_bullet_pkg: bullet geometry, timing, colour and FSM state type
package player_bullet_pkg;

    localparam int          BULLET_W        = 4;
    localparam int          BULLET_H        = 8;
    localparam int          BULLET_SPEED    = 6;
    localparam int          COOLDOWN_FRAMES = 10;
    localparam logic [23:0] BULLET_COLOR    = 24'hFFFF00;

    typedef enum logic [1:0] {B_IDLE, B_FLYING, B_COOLDOWN} bullet_state_t;

endpackage

// File: rtl/fire_sync.sv
// fire_sync: 2-FF synchroniser for the raw fire button plus rising-edge pulse
module fire_sync (
    input  logic pixel_clk,
    input  logic rst_n,
    input  logic fire_i,
    output logic rise_o
);

    logic [2:0] sync_q;

    // Two metastability stages followed by a history flop for edge detection
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 3'b000;
        else        sync_q <= {sync_q[1:0], fire_i};
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/player_bullet.sv
// player_bullet: fire-button driven projectile with per-frame motion, cooldown and raster compare
module player_bullet
    import player_bullet_pkg::*;
(
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic               fsync,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    input  logic               fire,
    input  logic signed [11:0] ship_x,
    input  logic signed [11:0] ship_top_y,
    input  logic               hit,
    output logic signed [11:0] bullet_x,
    output logic signed [11:0] bullet_y,
    output logic               bullet_active,
    output logic [7:0]         pixel [0:2],
    output logic               active,
    output logic [7:0]         shots_fired
);

    localparam logic signed [11:0] H12  = 12'(BULLET_H);
    localparam logic signed [11:0] S12  = 12'(BULLET_SPEED);
    localparam logic signed [11:0] HW12 = 12'(BULLET_W / 2);

    bullet_state_t      state_q, state_d;
    logic signed [11:0] x_q, x_d, y_q, y_d;
    logic               act_q, act_d, req_q, req_d, rise;
    logic [7:0]         cnt_q, cnt_d, shots_q, shots_d;

    fire_sync u_fire_sync (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .fire_i    (fire),
        .rise_o    (rise)
    );

    // State, position, request and counter registers; reset kills any bullet in flight
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= B_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            act_q   <= 1'b0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            shots_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            act_q   <= act_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            shots_q <= shots_d;
        end
    end

    // Next-state: fire edges latch only in IDLE; all motion and transitions happen on fsync
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        shots_d = shots_q;
        req_d   = req_q | (rise && state_q == B_IDLE);
        if (fsync) begin
            case (state_q)
                B_IDLE: begin
                    if (req_q) begin
                        req_d = 1'b0;
                        if (ship_top_y >= H12) begin
                            x_d     = ship_x;
                            y_d     = ship_top_y - H12;
                            act_d   = 1'b1;
                            shots_d = (shots_q == 8'hFF) ? shots_q : shots_q + 8'd1;
                            state_d = B_FLYING;
                        end
                    end
                end
                B_FLYING: begin
                    if (hit || y_q < S12) begin
                        act_d   = 1'b0;
                        cnt_d   = 8'(COOLDOWN_FRAMES);
                        state_d = B_COOLDOWN;
                    end else begin
                        y_d = y_q - S12;
                    end
                end
                B_COOLDOWN: begin
                    state_d = (cnt_q == 8'd0) ? B_IDLE : B_COOLDOWN;
                    cnt_d   = (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
                end
                default: state_d = B_IDLE;
            endcase
        end
    end

    assign bullet_x      = x_q;
    assign bullet_y      = y_q;
    assign bullet_active = act_q;
    assign shots_fired   = shots_q;

    assign active = act_q
                 && hpos >= x_q - HW12 && hpos <= x_q + HW12 - 12'sd1
                 && vpos >= y_q        && vpos <= y_q + H12 - 12'sd1;

    assign pixel[0] = active ? BULLET_COLOR[7:0]   : 8'h00;
    assign pixel[1] = active ? BULLET_COLOR[15:8]  : 8'h00;
    assign pixel[2] = active ? BULLET_COLOR[23:16] : 8'h00;

endmodule

// File: tb/tb_player_bullet.sv
// tb_player_bullet: randomized scoreboard bench with a frame-level reference model
module tb_player_bullet;

    localparam int W = 4, H = 8, SPD = 6, CD = 10;

    logic               pixel_clk = 1'b0, rst_n = 1'b0, fsync = 1'b0, fire = 1'b0, hit = 1'b0;
    logic signed [11:0] hpos = '0, vpos = '0, ship_x = '0, ship_top_y = '0;
    logic signed [11:0] bullet_x, bullet_y;
    logic               bullet_active, active;
    logic [7:0]         pixel [0:2];
    logic [7:0]         shots_fired;

    player_bullet dut (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .fsync         (fsync),
        .hpos          (hpos),
        .vpos          (vpos),
        .fire          (fire),
        .ship_x        (ship_x),
        .ship_top_y    (ship_top_y),
        .hit           (hit),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_active (bullet_active),
        .pixel         (pixel),
        .active        (active),
        .shots_fired   (shots_fired)
    );

    always #5 pixel_clk = ~pixel_clk;

    int cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    typedef struct {bit frame; int c; int x; int y; int act; int shots; int ract;} exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;

    int m_st = 0, m_x = 0, m_y = 0, m_act = 0, m_cnt = 0, m_shots = 0, m_pend = 0;
    bit fire_prev = 0;

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge pixel_clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            if (e.frame) begin
                chk("frame_x", bullet_x, e.x);
                chk("frame_y", bullet_y, e.y);
                chk("frame_active", bullet_active, e.act);
                chk("frame_shots", shots_fired, e.shots);
            end else begin
                chk("raster_active", active, e.ract);
                chk("raster_pixel", {pixel[0], pixel[1], pixel[2]}, e.ract ? 24'h00FFFF : 0);
            end
        end
    end

    function automatic int ract(int hp, int vp);
        return int'(m_act != 0 && hp >= m_x - W/2 && hp <= m_x + W/2 - 1 && vp >= m_y && vp <= m_y + H - 1);
    endfunction

    task automatic model_fsync(int sx, int sty, bit h);
        if (m_st == 0) begin
            if (m_pend != 0) begin
                m_pend = 0;
                if (sty >= H) begin
                    m_x = sx; m_y = sty - H; m_act = 1; m_st = 1;
                    if (m_shots < 255) m_shots++;
                end
            end
        end else if (m_st == 1) begin
            if (h || m_y < SPD) begin m_act = 0; m_cnt = CD; m_st = 2; end
            else m_y -= SPD;
        end else begin
            if (m_cnt == 0) m_st = 0;
            else m_cnt--;
        end
    endtask

    task automatic probe(int hp, int vp, int e);
        @(posedge pixel_clk); #1;
        hpos = 12'(hp); vpos = 12'(vp);
        q.push_back('{1'b0, cyc, 0, 0, 0, 0, e});
    endtask

    task automatic frame(bit f, bit h, int sx, int sty, int np);
        @(posedge pixel_clk); #1;
        fsync = 1'b1; hit = h; ship_x = 12'(sx); ship_top_y = 12'(sty);
        model_fsync(sx, sty, h);
        q.push_back('{1'b1, cyc + 1, m_x, m_y, m_act, m_shots, 0});
        @(posedge pixel_clk); #1;
        fsync = 1'b0; hit = 1'b0; fire = f;
        if (f && !fire_prev && m_st == 0) m_pend = 1;
        fire_prev = f;
        for (int i = 0; i < np; i++) begin
            int hp, vp;
            hp = m_x + int'($urandom_range(0, 7)) - 4;
            vp = m_y + int'($urandom_range(0, 11)) - 2;
            probe(hp, vp, ract(hp, vp));
        end
        repeat (8 - np) @(posedge pixel_clk);
    endtask

    task automatic launch(int sx, int sty);
        if (fire_prev) frame(0, 0, sx, sty, 0);
        while (m_st != 0) frame(0, 0, sx, sty, 0);
        frame(1, 0, sx, sty, 0);
        frame(0, 0, sx, sty, 0);
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        rst_n = 1'b0; fire = 1'b0;
        #1;
        chk("rst_bullet_active", bullet_active, 0);
        chk("rst_shots", shots_fired, 0);
        chk("rst_x", bullet_x, 0);
        chk("rst_y", bullet_y, 0);
        m_st = 0; m_x = 0; m_y = 0; m_act = 0; m_cnt = 0; m_shots = 0; m_pend = 0; fire_prev = 0;
        @(negedge pixel_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int s0;
        #12;
        chk("init_active", bullet_active, 0);
        chk("init_shots", shots_fired, 0);
        chk("init_raster", active, 0);
        @(negedge pixel_clk);
        rst_n = 1'b1;

        launch(320, 440);
        chk("launch_x", bullet_x, 320);
        chk("launch_y", bullet_y, 432);
        chk("launch_active", bullet_active, 1);
        chk("launch_shots", shots_fired, 1);
        frame(0, 0, 320, 440, 0);
        chk("step_y", bullet_y, 426);

        do_reset();
        launch(50, 208);
        chk("midflight_y", bullet_y, 200);
        do_reset();

        launch(200, 13);
        chk("top_launch_y", bullet_y, 5);
        s0 = m_shots;
        frame(0, 0, 200, 13, 0);
        chk("top_retire", bullet_active, 0);
        frame(1, 0, 200, 13, 0);
        repeat (8) frame(0, 0, 200, 13, 0);
        frame(1, 0, 200, 13, 0);
        frame(0, 0, 200, 13, 0);
        chk("cooldown_no_launch", shots_fired, s0);
        frame(1, 0, 200, 13, 0);
        frame(0, 0, 200, 13, 0);
        chk("post_cooldown_launch", shots_fired, s0 + 1);

        launch(400, 308);
        chk("hit_pre_y", bullet_y, 300);
        frame(0, 1, 400, 308, 0);
        chk("hit_active", bullet_active, 0);
        chk("hit_y_frozen", bullet_y, 300);
        while (m_st != 0) frame(0, 0, 400, 308, 0);
        s0 = m_shots;
        frame(0, 1, 400, 308, 0);
        chk("idle_hit_shots", shots_fired, s0);

        launch(100, 58);
        probe(98, 50, 1);
        probe(101, 57, 1);
        probe(102, 50, 0);
        probe(98, 58, 0);
        probe(97, 50, 0);
        probe(99, 49, 0);

        while (m_st != 0) frame(0, 0, 100, 58, 0);
        s0 = m_shots;
        repeat (45) frame(1, 0, 150, 20, 0);
        chk("held_fire_one_launch", shots_fired, s0 + 1);
        frame(0, 0, 150, 20, 0);

        for (int i = 0; i < 300; i++) begin
            int sty;
            sty = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(8, 479));
            frame($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 639)), sty, int'($urandom_range(0, 4)));
        end

        for (int i = 0; i < 260; i++) launch(60, 8);
        chk("shots_saturate", shots_fired, 255);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge pixel_clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
